// File: rtl/leaf_router_pkg.sv
// Shared types and helpers for the buffered leaf router.
// The group field sits in the top GROUP_W bits of a destination address.
package leaf_router_pkg;

    localparam int GROUP_W         = 4;
    // Widest destination address that is_local() accepts (callers zero-extend).
    localparam int HELPER_ADDR_MAX = 16;
    // Flit field widths for the default configuration.
    localparam int FLIT_DWIDTH     = 16;
    localparam int FLIT_ADDR_W     = 6;

    typedef struct packed {
        logic [FLIT_ADDR_W-1:0] dest;
        logic [FLIT_DWIDTH-1:0] data;
    } flit_t;

    // True when the group field of an addr_w-bit destination matches group.
    function automatic logic is_local(input logic [HELPER_ADDR_MAX-1:0] dest,
                                      input int                         addr_w,
                                      input logic [GROUP_W-1:0]         group);
        logic [HELPER_ADDR_MAX-1:0] shifted;
        shifted = dest >> (addr_w - GROUP_W);
        return shifted[GROUP_W-1:0] == group;
    endfunction

endpackage

// File: rtl/leaf_router_buffered_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module router_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_next = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array write.
    // NOTE: the storage array has no reset; its contents are meaningless while empty is set.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer and registered flag update.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            empty  <= (wr_next == rd_next);
            full   <= (wr_next == {~rd_next[AW], rd_next[AW-1:0]});
        end
    end

endmodule

// File: rtl/leaf_router_buffered.sv
// Buffered leaf router: one GPU port, NUM_SPINES spine ports, ingress FIFOs,
// valid/ready egress registers and a round-robin arbiter for GPU egress.
// Optional feature: define LEAF_ROUTER_DROP_CNT_EN for the drop_count port.
module leaf_router_buffered
    import leaf_router_pkg::*;
#(
    parameter int                 DWIDTH     = 16,
    parameter int                 ADDR_W     = 6,
    parameter int                 NUM_SPINES = 4,
    parameter int                 FIFO_DEPTH = 8,
    parameter logic [GROUP_W-1:0] GROUP_ID   = 4'b0111,
    localparam int                SW         = $clog2(NUM_SPINES),
    localparam int                NP         = NUM_SPINES + 1,
    localparam int                GW         = $clog2(NUM_SPINES + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                arb_enable,
    input  logic [DWIDTH-1:0]                   gpu_in_data,
    input  logic [ADDR_W-1:0]                   gpu_in_dest,
    input  logic                                gpu_in_valid,
    output logic                                gpu_in_ready,
    output logic [DWIDTH-1:0]                   gpu_out_data,
    output logic [ADDR_W-1:0]                   gpu_out_dest,
    output logic                                gpu_out_valid,
    input  logic                                gpu_out_ready,
    input  logic [NUM_SPINES-1:0][DWIDTH-1:0]   spine_in_data,
    input  logic [NUM_SPINES-1:0][ADDR_W-1:0]   spine_in_dest,
    input  logic [NUM_SPINES-1:0]               spine_in_valid,
    output logic [NUM_SPINES-1:0]               spine_in_ready,
    output logic [NUM_SPINES-1:0][DWIDTH-1:0]   spine_out_data,
    output logic [NUM_SPINES-1:0][ADDR_W-1:0]   spine_out_dest,
    output logic [NUM_SPINES-1:0]               spine_out_valid,
    input  logic [NUM_SPINES-1:0]               spine_out_ready,
    output logic [NUM_SPINES:0]                 fifo_full,
    output logic [NUM_SPINES:0]                 fifo_empty,
    output logic                                crossbar_busy,
`ifdef LEAF_ROUTER_DROP_CNT_EN
    output logic [15:0]                         drop_count,
`endif
    output logic [GW-1:0]                       current_grant
);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DWIDTH-1:0] data;
    } route_flit_t;

    route_flit_t [NP-1:0]   fifo_din, fifo_dout;
    logic [NP-1:0]          in_valid_all, fifo_push, fifo_pop;
    logic [NP-1:0]          head_local, req, drop_vec;
    logic [NUM_SPINES-1:0]  spine_free;
    logic [SW-1:0]          gpu_sel;
    logic                   gpu_to_spine, gpu_free;
    logic                   grant_found, grant;
    logic [GW-1:0]          grant_idx;

    // Ingress gather: index NUM_SPINES is the GPU port.
    always_comb begin
        for (int i = 0; i < NUM_SPINES; i++) begin
            fifo_din[i]     = '{dest: spine_in_dest[i], data: spine_in_data[i]};
            in_valid_all[i] = spine_in_valid[i];
        end
        fifo_din[NUM_SPINES]     = '{dest: gpu_in_dest, data: gpu_in_data};
        in_valid_all[NUM_SPINES] = gpu_in_valid;
    end

    assign fifo_push      = in_valid_all & ~fifo_full;
    assign gpu_in_ready   = !fifo_full[NUM_SPINES];
    assign spine_in_ready = ~fifo_full[NUM_SPINES-1:0];

    for (genvar i = 0; i < NP; i++) begin : g_fifo
        router_sync_fifo #(
            .WIDTH ($bits(route_flit_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .din   (fifo_din[i]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Head classification: local heads request GPU egress, foreign spine heads are dropped.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            head_local[i] = is_local(HELPER_ADDR_MAX'(fifo_dout[i].dest), ADDR_W, GROUP_ID);
        end
        req      = head_local & ~fifo_empty;
        drop_vec = {1'b0, ~head_local[NUM_SPINES-1:0] & ~fifo_empty[NUM_SPINES-1:0]};
    end

    assign spine_free   = ~spine_out_valid | spine_out_ready;
    assign gpu_free     = !gpu_out_valid || gpu_out_ready;
    assign gpu_sel      = fifo_dout[NUM_SPINES].dest[SW-1:0];
    assign gpu_to_spine = !fifo_empty[NUM_SPINES] && !head_local[NUM_SPINES] && spine_free[gpu_sel];

    // Round-robin search starting one past the last winner, wrapping over NP requestors.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = current_grant;
        for (int off = 1; off <= NP; off++) begin
            cand = (int'(current_grant) + off) % NP;
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(cand);
            end
        end
    end

    assign grant = arb_enable && gpu_free && grant_found;

    // Pop selection: dropped spine heads, the GPU-egress winner, and the GPU head bound for a spine.
    always_comb begin
        fifo_pop = drop_vec;
        if (grant)        fifo_pop[grant_idx]  = 1'b1;
        if (gpu_to_spine) fifo_pop[NUM_SPINES] = 1'b1;
    end

    // GPU egress register and last-winner pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpu_out_valid <= 1'b0;
            gpu_out_data  <= '0;
            gpu_out_dest  <= '0;
            current_grant <= GW'(NUM_SPINES);
        end else if (grant) begin
            gpu_out_valid <= 1'b1;
            gpu_out_data  <= fifo_dout[grant_idx].data;
            gpu_out_dest  <= fifo_dout[grant_idx].dest;
            current_grant <= grant_idx;
        end else if (gpu_out_ready) begin
            gpu_out_valid <= 1'b0;
        end
    end

    // Spine egress registers, loaded only from the GPU FIFO head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spine_out_valid <= '0;
            spine_out_data  <= '0;
            spine_out_dest  <= '0;
        end else begin
            for (int s = 0; s < NUM_SPINES; s++) begin
                if (gpu_to_spine && gpu_sel == SW'(s)) begin
                    spine_out_valid[s] <= 1'b1;
                    spine_out_data[s]  <= fifo_dout[NUM_SPINES].data;
                    spine_out_dest[s]  <= fifo_dout[NUM_SPINES].dest;
                end else if (spine_out_ready[s]) begin
                    spine_out_valid[s] <= 1'b0;
                end
            end
        end
    end

    assign crossbar_busy = !(&fifo_empty) || gpu_out_valid || (|spine_out_valid);

`ifdef LEAF_ROUTER_DROP_CNT_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_count} + 17'($countones(drop_vec));

    // Saturating count of discarded misrouted spine packets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_count <= '0;
        else       drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_leaf_router_buffered.sv
// Scoreboard bench for leaf_router_buffered (default parameters).
// Stimulus pushes expected egress flits into per-port queues; a negedge
// monitor pops and compares on every valid & ready handshake.
module tb_leaf_router_buffered;
    import leaf_router_pkg::*;

    localparam int NS = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   arb_enable;
    logic [15:0]            gpu_in_data;
    logic [5:0]             gpu_in_dest;
    logic                   gpu_in_valid;
    logic                   gpu_in_ready;
    logic [15:0]            gpu_out_data;
    logic [5:0]             gpu_out_dest;
    logic                   gpu_out_valid;
    logic                   gpu_out_ready;
    logic [NS-1:0][15:0]    spine_in_data;
    logic [NS-1:0][5:0]     spine_in_dest;
    logic [NS-1:0]          spine_in_valid;
    logic [NS-1:0]          spine_in_ready;
    logic [NS-1:0][15:0]    spine_out_data;
    logic [NS-1:0][5:0]     spine_out_dest;
    logic [NS-1:0]          spine_out_valid;
    logic [NS-1:0]          spine_out_ready;
    logic [NS:0]            fifo_full;
    logic [NS:0]            fifo_empty;
    logic                   crossbar_busy;
    logic [2:0]             current_grant;
`ifdef LEAF_ROUTER_DROP_CNT_EN
    logic [15:0]            drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    flit_t gpu_q[$];
    flit_t spine_q[NS][$];

    leaf_router_buffered dut (
        .clk             (clk),
        .reset           (reset),
        .arb_enable      (arb_enable),
        .gpu_in_data     (gpu_in_data),
        .gpu_in_dest     (gpu_in_dest),
        .gpu_in_valid    (gpu_in_valid),
        .gpu_in_ready    (gpu_in_ready),
        .gpu_out_data    (gpu_out_data),
        .gpu_out_dest    (gpu_out_dest),
        .gpu_out_valid   (gpu_out_valid),
        .gpu_out_ready   (gpu_out_ready),
        .spine_in_data   (spine_in_data),
        .spine_in_dest   (spine_in_dest),
        .spine_in_valid  (spine_in_valid),
        .spine_in_ready  (spine_in_ready),
        .spine_out_data  (spine_out_data),
        .spine_out_dest  (spine_out_dest),
        .spine_out_valid (spine_out_valid),
        .spine_out_ready (spine_out_ready),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .crossbar_busy   (crossbar_busy),
`ifdef LEAF_ROUTER_DROP_CNT_EN
        .drop_count      (drop_count),
`endif
        .current_grant   (current_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_gpu(input logic [15:0] d, input logic [5:0] a);
        gpu_q.push_back('{dest: a, data: d});
    endtask

    task automatic expect_spine(input int s, input logic [15:0] d, input logic [5:0] a);
        spine_q[s].push_back('{dest: a, data: d});
    endtask

    // Push one GPU word, waiting a bounded number of cycles for ready.
    task automatic push_gpu(input logic [15:0] d, input logic [5:0] a);
        int n;
        n            = 0;
        gpu_in_data  = d;
        gpu_in_dest  = a;
        gpu_in_valid = 1'b1;
        while (!gpu_in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL push_gpu_timeout: gpu_in_ready stuck at 0");
        end
        step();
        gpu_in_valid = 1'b0;
    endtask

    function automatic bit queues_empty();
        bit e;
        e = (gpu_q.size() == 0);
        for (int s = 0; s < NS; s++) e &= (spine_q[s].size() == 0);
        return e;
    endfunction

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!queues_empty() && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (!queues_empty()) begin
            failures++;
            $display("FAIL %s_drain_timeout: gpu_q=%0d outstanding after %0d cycles", name, gpu_q.size(), n);
        end
    endtask

    // Monitor: compare every egress handshake against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (gpu_out_valid && gpu_out_ready) begin
                if (gpu_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL gpu_unexpected: got data %h dest %h, expected nothing", gpu_out_data, gpu_out_dest);
                end else begin
                    flit_t e;
                    e = gpu_q.pop_front();
                    check("gpu_out_data", 32'(gpu_out_data), 32'(e.data));
                    check("gpu_out_dest", 32'(gpu_out_dest), 32'(e.dest));
                end
            end
            for (int s = 0; s < NS; s++) begin
                if (spine_out_valid[s] && spine_out_ready[s]) begin
                    if (spine_q[s].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spine%0d_unexpected: got data %h dest %h, expected nothing", s, spine_out_data[s], spine_out_dest[s]);
                    end else begin
                        flit_t e;
                        e = spine_q[s].pop_front();
                        check($sformatf("spine%0d_out_data", s), 32'(spine_out_data[s]), 32'(e.data));
                        check($sformatf("spine%0d_out_dest", s), 32'(spine_out_dest[s]), 32'(e.dest));
                    end
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        arb_enable      = 1'b1;
        gpu_in_data     = '0;
        gpu_in_dest     = '0;
        gpu_in_valid    = 1'b0;
        gpu_out_ready   = 1'b1;
        spine_in_data   = '0;
        spine_in_dest   = '0;
        spine_in_valid  = '0;
        spine_out_ready = '1;
        repeat (3) step();

        // Reset state.
        check("rst_fifo_empty", 32'(fifo_empty), 32'h1F);
        check("rst_fifo_full", 32'(fifo_full), 32'h0);
        check("rst_gpu_out_valid", 32'(gpu_out_valid), 32'h0);
        check("rst_spine_out_valid", 32'(spine_out_valid), 32'h0);
        check("rst_gpu_out_data", 32'(gpu_out_data), 32'h0);
        check("rst_spine_out_data", 32'(spine_out_data[2]), 32'h0);
        check("rst_busy", 32'(crossbar_busy), 32'h0);
        check("rst_grant", 32'(current_grant), 32'd4);
        reset = 1'b0;
        step();
        check("rst_gpu_in_ready", 32'(gpu_in_ready), 32'h1);
        check("rst_spine_in_ready", 32'(spine_in_ready), 32'hF);
`ifdef LEAF_ROUTER_DROP_CNT_EN
        check("rst_drop_count", 32'(drop_count), 32'h0);
`endif

        // GPU to spine 2 (group 3): valid in cycle N+2 only on spine 2.
        gpu_in_data  = 16'hA5A5;
        gpu_in_dest  = 6'b001110;
        gpu_in_valid = 1'b1;
        expect_spine(2, 16'hA5A5, 6'b001110);
        step();
        gpu_in_valid = 1'b0;
        check("g2s_n1_valid", 32'(spine_out_valid), 32'h0);
        step();
        check("g2s_n2_valid", 32'(spine_out_valid), 32'h4);
        check("g2s_n2_gpu_valid", 32'(gpu_out_valid), 32'h0);
        wait_drain("g2s", 10);

        // Round-robin: all four spines push a local word in the same cycle.
        for (int k = 0; k < NS; k++) begin
            spine_in_data[k] = 16'h1000 + 16'(k);
            spine_in_dest[k] = 6'b011100;
            expect_gpu(16'h1000 + 16'(k), 6'b011100);
        end
        spine_in_valid = 4'hF;
        step();
        spine_in_valid = '0;
        step();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rr_valid_cycle%0d", c), 32'(gpu_out_valid), 32'h1);
            step();
        end
        check("rr_valid_after", 32'(gpu_out_valid), 32'h0);
        check("rr_grant_final", 32'(current_grant), 32'd3);
        wait_drain("rr", 10);

        // Backpressure on spine 1: nine words accepted, the tenth refused.
        spine_out_ready = 4'b1101;
        for (int i = 0; i < 9; i++) begin
            push_gpu(16'hB000 + 16'(i), 6'b000101);
            expect_spine(1, 16'hB000 + 16'(i), 6'b000101);
        end
        gpu_in_data  = 16'hBEEF;
        gpu_in_dest  = 6'b000101;
        gpu_in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("bp_gpu_in_ready", 32'(gpu_in_ready), 32'h0);
            check("bp_fifo_full_gpu", 32'(fifo_full[4]), 32'h1);
            check("bp_spine1_valid", 32'(spine_out_valid[1]), 32'h1);
            check("bp_spine1_hold", 32'(spine_out_data[1]), 32'hB000);
            step();
        end
        gpu_in_valid    = 1'b0;
        spine_out_ready = 4'hF;
        wait_drain("bp", 40);
        step();
        check("bp_empty_after", 32'(fifo_empty), 32'h1F);

        // Misroute: spine 3 sends three group-2 words; all dropped.
        spine_in_dest[3] = 6'b001000;
        for (int i = 0; i < 3; i++) begin
            spine_in_data[3]  = 16'hD000 + 16'(i);
            spine_in_valid[3] = 1'b1;
            step();
        end
        spine_in_valid = '0;
        repeat (3) step();
        check("mis_fifo3_empty", 32'(fifo_empty[3]), 32'h1);
        check("mis_gpu_valid", 32'(gpu_out_valid), 32'h0);
        check("mis_busy", 32'(crossbar_busy), 32'h0);
`ifdef LEAF_ROUTER_DROP_CNT_EN
        check("mis_drop_count", 32'(drop_count), 32'd3);
`endif

        // arb_enable low: spine 0, spine 2 and GPU loopback words wait.
        arb_enable       = 1'b0;
        spine_in_data[0] = 16'hC000;
        spine_in_dest[0] = 6'b011100;
        spine_in_data[2] = 16'hC002;
        spine_in_dest[2] = 6'b011110;
        spine_in_valid   = 4'b0101;
        gpu_in_data      = 16'hC004;
        gpu_in_dest      = 6'b011101;
        gpu_in_valid     = 1'b1;
        // Last winner is 3, so the order is GPU (4), spine 0, spine 2.
        expect_gpu(16'hC004, 6'b011101);
        expect_gpu(16'hC000, 6'b011100);
        expect_gpu(16'hC002, 6'b011110);
        step();
        spine_in_valid = '0;
        gpu_in_valid   = 1'b0;
        repeat (4) begin
            check("arb_off_gpu_valid", 32'(gpu_out_valid), 32'h0);
            step();
        end
        check("arb_off_fifo_empty", 32'(fifo_empty), 32'b01010);
        arb_enable = 1'b1;
        wait_drain("arb", 10);
        check("arb_grant_final", 32'(current_grant), 32'd2);

        // Reset with five words queued behind a disabled arbiter.
        arb_enable       = 1'b0;
        spine_in_dest[0] = 6'b011100;
        for (int i = 0; i < 5; i++) begin
            spine_in_data[0]  = 16'hE000 + 16'(i);
            spine_in_valid[0] = 1'b1;
            step();
        end
        spine_in_valid = '0;
        step();
        check("prerst_fifo0_empty", 32'(fifo_empty[0]), 32'h0);
        check("prerst_busy", 32'(crossbar_busy), 32'h1);
        reset = 1'b1;
        #2;
        check("midrst_fifo_empty", 32'(fifo_empty), 32'h1F);
        check("midrst_gpu_valid", 32'(gpu_out_valid), 32'h0);
        check("midrst_spine_valid", 32'(spine_out_valid), 32'h0);
        check("midrst_busy", 32'(crossbar_busy), 32'h0);
        check("midrst_grant", 32'(current_grant), 32'd4);
        step();
        reset      = 1'b0;
        arb_enable = 1'b1;
        repeat (8) step();
        check("postrst_fifo_empty", 32'(fifo_empty), 32'h1F);
        check("postrst_busy", 32'(crossbar_busy), 32'h0);
        checks++;
        if (!queues_empty()) begin
            failures++;
            $display("FAIL scoreboard_leftover: gpu_q=%0d entries remain, expected 0", gpu_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

endmodule
